// File: rtl/parity_pkg.sv
// Shared types and helpers for the even-parity generator/transmitter pair.
// Holds the frame FSM encoding and the parity function both ends agree on.
package parity_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int FRAME_BITS = DATA_W_DEF + 3;
  localparam int PAR_MAX_W  = 32;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_e;

  function automatic logic even_parity(
    input logic [PAR_MAX_W-1:0] data
  );
    return ^data;
  endfunction

endpackage

// File: rtl/parity_tx_bit_timer.sv
// Bit-period counter: runs 0..CLKS_PER_BIT-1 while enabled, tick on last.
// Held at zero whenever disabled so every frame starts on a clean period.
module parity_tx_bit_timer #(
  parameter int CLKS_PER_BIT = 4,
  localparam int CW = $clog2(CLKS_PER_BIT)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  output logic          bit_tick,
  output logic [CW-1:0] cnt
);

  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign bit_tick = en && (cnt_q == LAST);
  assign cnt      = cnt_q;

  always_comb begin
    cnt_d = '0;
    if (en && !bit_tick) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/parity_frame_tx.sv
// Serializes a byte plus its supplied parity bit as start/data/parity/stop,
// and flags when the supplied parity disagrees with the local recompute.
module parity_frame_tx
  import parity_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_pe,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              tx,
  output logic              busy,
  output logic              done,
  output logic              par_err
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);
  localparam logic [CW-1:0] PRE_LAST = CW'(CLKS_PER_BIT - 2);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              pe_q, pe_d;
  logic [BW-1:0]     bit_q, bit_d;
  logic              tx_q, tx_d;
  logic              busy_q, busy_d;
  logic              ready_q, ready_d;
  logic              done_q, done_d;
  logic              perr_q, perr_d;

  logic          tick;
  logic [CW-1:0] cnt;
  logic          accept;

  assign accept = in_valid && ready_q;

  parity_tx_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (state_q != IDLE),
    .bit_tick(tick),
    .cnt     (cnt)
  );

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    pe_d    = pe_q;
    bit_d   = bit_q;
    unique case (state_q)
      IDLE: if (accept) begin
        shift_d = in_data;
        pe_d    = in_pe;
        bit_d   = '0;
        state_d = START;
      end
      START: if (tick) state_d = DATA;
      DATA: if (tick) begin
        shift_d = shift_q >> 1;
        if (bit_q == LAST_BIT) begin
          bit_d   = '0;
          state_d = PARITY;
        end else begin
          bit_d = bit_q + 1'b1;
        end
      end
      PARITY: if (tick) state_d = STOP;
      STOP:   if (tick) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Line level is computed for the coming state so tx leaves a flop.
  always_comb begin
    tx_d = 1'b1;
    unique case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      PARITY:  tx_d = pe_d;
      default: tx_d = 1'b1;
    endcase
  end

  assign busy_d  = (state_d != IDLE);
  assign ready_d = (state_d == IDLE);
  assign done_d  = (state_q == STOP) && (cnt == PRE_LAST);
  assign perr_d  = accept &&
                   (in_pe != even_parity(PAR_MAX_W'(in_data)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      shift_q <= '0;
      pe_q    <= 1'b0;
      bit_q   <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      pe_q    <= pe_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      ready_q <= ready_d;
      done_q  <= done_d;
      perr_q  <= perr_d;
    end
  end

  assign in_ready = ready_q;
  assign tx       = tx_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign par_err  = perr_q;

endmodule

// File: tb/tb_parity_frame_tx.sv
// Directed bench for parity_frame_tx: framing, parity flag, spacing, reset.
// Expected line patterns are built from the frame format, not the DUT.
module tb_parity_frame_tx;
  import parity_pkg::*;

  localparam int CPB = 4;
  localparam int FCYC = FRAME_BITS * CPB;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] in_data;
  logic       in_pe;
  logic       in_valid;
  logic       in_ready;
  logic       tx;
  logic       busy;
  logic       done;
  logic       par_err;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int acc_q[$];

  parity_frame_tx #(
    .DATA_W(8),
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .in_data (in_data),
    .in_pe   (in_pe),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .tx      (tx),
    .busy    (busy),
    .done    (done),
    .par_err (par_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc++;
    if (rst_n && in_valid && in_ready) acc_q.push_back(cyc);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [FCYC-1:0] exp_tx(input logic [7:0] d,
                                             input logic pe);
    logic [FCYC-1:0] v;
    int b;
    for (int c = 0; c < FCYC; c++) begin
      b = c / CPB;
      if (b == 0)      v[c] = 1'b0;
      else if (b <= 8) v[c] = d[b-1];
      else if (b == 9) v[c] = pe;
      else             v[c] = 1'b1;
    end
    return v;
  endfunction

  task automatic send(input logic [7:0] d, input logic pe,
                      input bit keep);
    bit ok;
    in_data = d;
    in_pe = pe;
    in_valid = 1'b1;
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      if (in_ready) begin
        ok = 1;
        break;
      end
      @(posedge clk);
      #1;
    end
    if (!ok) chk("accept_timeout", 64'(0), 64'(1));
    @(posedge clk);
    #1;
    if (!keep) in_valid = 1'b0;
  endtask

  task automatic capture(output logic [FCYC-1:0] txv,
                         output logic [FCYC-1:0] donev,
                         output logic [FCYC-1:0] busyv,
                         output logic [FCYC-1:0] perrv);
    for (int i = 0; i < FCYC; i++) begin
      txv[i] = tx;
      donev[i] = done;
      busyv[i] = busy;
      perrv[i] = par_err;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_frame(input string nm, input logic [7:0] d,
                             input logic pe,
                             input logic [FCYC-1:0] txv,
                             input logic [FCYC-1:0] donev,
                             input logic [FCYC-1:0] busyv,
                             input logic [FCYC-1:0] perrv,
                             input bit perr_exp);
    logic [FCYC-1:0] dexp;
    logic [FCYC-1:0] pexp;
    dexp = '0;
    dexp[FCYC-1] = 1'b1;
    pexp = '0;
    pexp[0] = perr_exp;
    chk($sformatf("%s_tx", nm), 64'(txv), 64'(exp_tx(d, pe)));
    chk($sformatf("%s_done", nm), 64'(donev), 64'(dexp));
    chk($sformatf("%s_busy", nm), 64'(busyv), 64'({FCYC{1'b1}}));
    chk($sformatf("%s_perr", nm), 64'(perrv), 64'(pexp));
  endtask

  task automatic frame(input string nm, input logic [7:0] d,
                       input logic pe, input bit perr_exp,
                       output logic [FCYC-1:0] txv);
    logic [FCYC-1:0] dv, bv, pv;
    send(d, pe, 0);
    capture(txv, dv, bv, pv);
    check_frame(nm, d, pe, txv, dv, bv, pv, perr_exp);
    chk($sformatf("%s_idle_tx", nm), 64'(tx), 64'(1));
    chk($sformatf("%s_idle_rdy", nm), 64'(in_ready), 64'(1));
  endtask

  initial begin
    logic [FCYC-1:0] tv, tv2, dv, bv, pv;
    logic [7:0] bits;
    logic seen;

    rst_n = 1'b1;
    in_data = '0;
    in_pe = 1'b0;
    in_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_tx", 64'(tx), 64'(1));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_rdy", 64'(in_ready), 64'(0));
    chk("rst_pulses", 64'({done, par_err}), 64'(0));
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    #1;
    chk("rel_rdy_before_edge", 64'(in_ready), 64'(0));
    @(posedge clk);
    #1;
    chk("rel_rdy", 64'(in_ready), 64'(1));
    chk("rel_idle", 64'({tx, busy, done, par_err}), 64'(4'b1000));

    frame("f00", 8'h00, 1'b0, 0, tv);

    frame("fA5", 8'hA5, 1'b0, 0, tv);
    for (int k = 0; k < 8; k++) bits[k] = tv[CPB + CPB * k + 2];
    chk("fA5_bits", 64'(bits), 64'(8'b1010_0101));
    chk("fA5_par", 64'(tv[9*CPB+1]), 64'(0));

    frame("f07p1", 8'h07, 1'b1, 0, tv);
    chk("f07p1_par", 64'(tv[9*CPB+2]), 64'(1));

    frame("f07p0", 8'h07, 1'b0, 1, tv);
    chk("f07p0_par", 64'(tv[9*CPB+2]), 64'(0));

    acc_q.delete();
    send(8'h01, 1'b1, 1);
    in_data = 8'h80;
    capture(tv, dv, bv, pv);
    check_frame("b2b_a", 8'h01, 1'b1, tv, dv, bv, pv, 0);
    chk("b2b_gap", 64'({tx, busy}), 64'(2'b10));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    capture(tv2, dv, bv, pv);
    check_frame("b2b_b", 8'h80, 1'b1, tv2, dv, bv, pv, 0);
    chk("b2b_nacc", 64'(acc_q.size()), 64'(2));
    if (acc_q.size() == 2)
      chk("b2b_space", 64'(acc_q[1] - acc_q[0]), 64'(45));

    send(8'hFF, 1'b0, 0);
    repeat (17) @(posedge clk);
    #1;
    chk("mid_busy", 64'(busy), 64'(1));
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst", 64'({tx, busy, in_ready}), 64'(3'b100));
    seen = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
      seen = seen | done | par_err | busy;
    end
    chk("mid_quiet", 64'(seen), 64'(0));
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    frame("f3C", 8'h3C, 1'b0, 0, tv);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/parity_frame_tx.md
Name: parity_frame_tx

Overview:
Downstream stage of the 8-bit even-parity generator. Consumes a data byte together with the generator's parity bit (PE) and serializes them as an asynchronous frame: start bit, data bits LSB first, parity bit, stop bit. It also recomputes even parity locally and flags any disagreement with the supplied PE, which cross-checks the upstream stage. Its output drives the serial line / test harness.

Parameters:
DATA_W, 8, number of data bits per frame
CLKS_PER_BIT, 4, clock cycles each serial bit is held (must be >= 2)

Ports:
clk  input  1  single system clock, rising-edge active
rst_n  input  1  asynchronous active-low reset
in_data  input  DATA_W  byte from the parity generator stage (the I value)
in_pe  input  1  even-parity bit supplied by the generator (PE)
in_valid  input  1  in_data/in_pe are valid
in_ready  output  1  block can accept a byte this cycle
tx  output  1  serial line, idles high
busy  output  1  frame in progress
done  output  1  one-cycle pulse at end of frame
par_err  output  1  one-cycle pulse when in_pe != ^in_data at acceptance

Behaviour:
- Reset: rst_n low forces all of the following immediately, without waiting for a clock edge: state=IDLE, tx=1, busy=0, done=0, par_err=0, in_ready=0. At the first clk edge after rst_n rises, in_ready goes to 1 (IDLE).
- States: IDLE -> START -> DATA -> PARITY -> STOP -> IDLE.
- IDLE: in_ready=1, tx=1, busy=0.
  - Acceptance: in_valid && in_ready at a rising edge.
  - On acceptance: latch in_data into a shift register and latch in_pe.
  - On acceptance: par_err=1 for the next cycle only, when in_pe != ^in_data (even parity rule: XOR of data bits equals PE).
  - On acceptance: go to START.
- START: tx=0 for CLKS_PER_BIT cycles.
- DATA: tx=shift[0] for CLKS_PER_BIT cycles per bit; shift right after each bit; bit counter runs 0..DATA_W-1.
- PARITY: tx=latched in_pe for CLKS_PER_BIT cycles. The supplied value is transmitted even when par_err fired, so a bad upstream shows up on the line.
- STOP: tx=1 for CLKS_PER_BIT cycles. done=1 during the last cycle of STOP, then IDLE.
- busy=1 and in_ready=0 in every state except IDLE.
- First START cycle is the cycle after acceptance. Frame length is exactly (DATA_W+3)*CLKS_PER_BIT cycles.
- Back-to-back: in_ready=1 the cycle after done, so minimum accept-to-accept spacing is (DATA_W+3)*CLKS_PER_BIT+1 cycles.
- in_valid while busy is ignored; no data is lost because in_ready=0.
- in_data and in_pe changes after acceptance have no effect on the frame in flight.
- Bit-period counter: width $clog2(CLKS_PER_BIT), counts 0..CLKS_PER_BIT-1, wraps to 0 on each bit boundary, held at 0 in IDLE.
- Reset mid-frame: tx returns to 1 immediately and the frame is abandoned. No done pulse; no par_err pulse.
- Outputs are registered; tx has no combinational path from any input.

Decomposition:
- Shared package parity_pkg:
  - state enum (IDLE, START, DATA, PARITY, STOP)
  - constant FRAME_BITS = DATA_W+3
  - function even_parity(data) returning ^data, reused by generator checks.
- One sub-module: parity_tx_bit_timer. It is the CLKS_PER_BIT cycle counter, with inputs clk, rst_n, en, and a one-cycle bit_tick output on the last cycle of each bit.
- FSM, shift register and bit counter stay in parity_frame_tx.

Test Plan:
- Reset then idle, CLKS_PER_BIT=4: hold rst_n=0 for 3 cycles, release -> tx=1, busy=0, in_ready=1 from the first edge after release; no done or par_err pulses.
- in_data=8'h00, in_pe=0 -> tx is 0 for 4 cycles (start), then 0x8 bits x4 cycles, parity 0 x4, stop 1 x4. done pulses in cycle 44 after acceptance; par_err stays 0.
- in_data=8'hA5, in_pe=0 -> data bits on tx, LSB first, are 1,0,1,0,0,1,0,1, each held 4 cycles; parity bit 0; par_err=0.
- in_data=8'h07, in_pe=1 -> parity bit 1. Repeat with in_pe=0 -> par_err pulses one cycle after acceptance and parity bit on tx is 0.
- Back-to-back: in_valid held high with 8'h01 then 8'h80 -> second acceptance exactly 45 cycles after the first; the two frames are separated by one idle-high cycle.
- Reset mid-frame: drop rst_n during data bit 3 of 8'hFF -> tx=1 and busy=0 before the next clk edge; no done pulse. A new byte 8'h3C sent after reset transmits correctly.
